// File: rtl/sparc_exu_yreg_file_pkg.sv
// Shared definitions for the per-thread Y register file: default sizes,
// next-value source encoding and reset value.
package sparc_exu_yreg_file_pkg;

    localparam int NTHR_DEF = 4;
    localparam int DW_DEF   = 32;
    localparam int DW_MAX   = 64;

    localparam logic [DW_MAX-1:0] YREG_RST = '0;

    typedef enum logic [1:0] {
        SRC_HOLD  = 2'd0,
        SRC_W     = 2'd1,
        SRC_G     = 2'd2,
        SRC_SHIFT = 2'd3
    } yreg_src_e;

endpackage

// File: rtl/sparc_exu_yreg_file_if.sv
// Write/shift/read bundle of the Y register file; master drives requests,
// slave (the register file) returns read data, lsb_l and err_coll.
interface sparc_exu_yreg_file_if #(
    parameter int NTHR = 4,
    parameter int DW   = 32
);
    logic [NTHR-1:0] wr_w_thr;
    logic [DW-1:0]   wr_w_data;
    logic [NTHR-1:0] wr_g_thr;
    logic [DW-1:0]   wr_g_data;
    logic [NTHR-1:0] shift_thr;
    logic            shift_in;
    logic [NTHR-1:0] rd_thr_e;
    logic [DW-1:0]   rd_data_e;
    logic [NTHR-1:0] lsb_l;
    logic            err_coll;

    modport master (
        output wr_w_thr, wr_w_data, wr_g_thr, wr_g_data,
        output shift_thr, shift_in, rd_thr_e,
        input  rd_data_e, lsb_l, err_coll
    );

    modport slave (
        input  wr_w_thr, wr_w_data, wr_g_thr, wr_g_data,
        input  shift_thr, shift_in, rd_thr_e,
        output rd_data_e, lsb_l, err_coll
    );
endinterface

// File: rtl/sparc_exu_yreg_file_entry.sv
// One thread's Y register: priority next-value mux (W > G > shift) and
// source-collision detect. SPARC_EXU_YREG_BYPASS_EN exposes the next value.
module sparc_exu_yreg_entry
    import sparc_exu_yreg_file_pkg::*;
#(
    parameter int DW = DW_DEF
) (
    input  logic          clk,
    input  logic          arst_l,
    input  logic          se,
    input  logic          i_w_en,
    input  logic [DW-1:0] i_w_data,
    input  logic          i_g_en,
    input  logic [DW-1:0] i_g_data,
    input  logic          i_sh_en,
    input  logic          i_sh_in,
    output logic          o_coll,
`ifdef SPARC_EXU_YREG_BYPASS_EN
    output logic [DW-1:0] o_nxt,
`endif
    output logic [DW-1:0] o_q
);

    yreg_src_e     w_src;
    logic [DW-1:0] w_nxt;
    logic [DW-1:0] r_q;
    logic          w_unused_se;

    // Scan stitching is added at netlist level; se is carried for port compatibility.
    assign w_unused_se = se;

    always_comb begin
        w_src = SRC_HOLD;
        if (i_w_en)
            w_src = SRC_W;
        else if (i_g_en)
            w_src = SRC_G;
        else if (i_sh_en)
            w_src = SRC_SHIFT;
    end

    always_comb begin
        w_nxt = r_q;
        case (w_src)
            SRC_W:     w_nxt = i_w_data;
            SRC_G:     w_nxt = i_g_data;
            SRC_SHIFT: w_nxt = {i_sh_in, r_q[DW-1:1]};
            default:   w_nxt = r_q;
        endcase
    end

    always_ff @(posedge clk or negedge arst_l) begin
        if (!arst_l)
            r_q <= YREG_RST[DW-1:0];
        else
            r_q <= w_nxt;
    end

    assign o_coll = (i_w_en & i_g_en) | (i_w_en & i_sh_en) | (i_g_en & i_sh_en);
    assign o_q    = r_q;
`ifdef SPARC_EXU_YREG_BYPASS_EN
    assign o_nxt  = w_nxt;
`endif

endmodule

// File: rtl/sparc_exu_yreg_file.sv
// Per-thread Y register file: staged W write slot, NTHR entries, read mux,
// lsb_l and registered err_coll. Optional read bypass: SPARC_EXU_YREG_BYPASS_EN.
module sparc_exu_yreg_file
    import sparc_exu_yreg_file_pkg::*;
#(
    parameter int NTHR = NTHR_DEF,
    parameter int DW   = DW_DEF
) (
    input  logic                   clk,
    input  logic                   arst_l,
    input  logic                   se,
    sparc_exu_yreg_file_if.slave   yif
);

    logic            r_pend_vld;
    logic [NTHR-1:0] r_pend_thr;
    logic [DW-1:0]   r_pend_data;
    logic            r_err_coll;

    logic [DW-1:0]   w_q      [NTHR];
    logic [DW-1:0]   w_rd_src [NTHR];
    logic [NTHR-1:0] w_coll;
    logic [NTHR-1:0] w_lsb_l;
    logic [DW-1:0]   w_rd_data;
    logic            w_err;

    function automatic logic multi_hot(input logic [NTHR-1:0] v);
        return (v & (v - NTHR'(1))) != '0;
    endfunction

    always_ff @(posedge clk or negedge arst_l) begin
        if (!arst_l) begin
            r_pend_vld <= 1'b0;
            r_pend_thr <= '0;
        end else begin
            r_pend_vld <= |yif.wr_w_thr;
            r_pend_thr <= yif.wr_w_thr;
        end
    end

    // Data half of the slot needs no reset: it is qualified by r_pend_vld.
    always_ff @(posedge clk) begin
        r_pend_data <= yif.wr_w_data;
    end

    for (genvar t = 0; t < NTHR; t++) begin : g_thr
        sparc_exu_yreg_entry #(.DW(DW)) u_entry (
            .clk      (clk),
            .arst_l   (arst_l),
            .se       (se),
            .i_w_en   (r_pend_vld & r_pend_thr[t]),
            .i_w_data (r_pend_data),
            .i_g_en   (yif.wr_g_thr[t]),
            .i_g_data (yif.wr_g_data),
            .i_sh_en  (yif.shift_thr[t]),
            .i_sh_in  (yif.shift_in),
            .o_coll   (w_coll[t]),
`ifdef SPARC_EXU_YREG_BYPASS_EN
            .o_nxt    (w_rd_src[t]),
`endif
            .o_q      (w_q[t])
        );

`ifndef SPARC_EXU_YREG_BYPASS_EN
        assign w_rd_src[t] = w_q[t];
`endif
        assign w_lsb_l[t] = ~w_q[t][0];
    end

    always_comb begin
        w_rd_data = '0;
        if (arst_l && !multi_hot(yif.rd_thr_e)) begin
            for (int t = 0; t < NTHR; t++) begin
                if (yif.rd_thr_e[t])
                    w_rd_data = w_rd_src[t];
            end
        end
    end

    assign w_err = (|w_coll)
                 | multi_hot(yif.wr_w_thr)
                 | multi_hot(yif.wr_g_thr)
                 | multi_hot(yif.shift_thr)
                 | multi_hot(yif.rd_thr_e);

    always_ff @(posedge clk or negedge arst_l) begin
        if (!arst_l)
            r_err_coll <= 1'b0;
        else
            r_err_coll <= w_err;
    end

    assign yif.rd_data_e = w_rd_data;
    assign yif.lsb_l     = w_lsb_l;
    assign yif.err_coll  = r_err_coll;

endmodule

// File: tb/tb_sparc_exu_yreg_file.sv
// Directed self-checking bench for sparc_exu_yreg_file (default, 8x64 and 1x8 builds).
module tb_sparc_exu_yreg_file;

    logic clk;
    logic arst_l;
    logic se;
    int   total;
    int   bad;

    sparc_exu_yreg_file_if #(.NTHR(4), .DW(32)) yif ();
    sparc_exu_yreg_file_if #(.NTHR(8), .DW(64)) yif8 ();
    sparc_exu_yreg_file_if #(.NTHR(1), .DW(8))  yif1 ();

    sparc_exu_yreg_file #(.NTHR(4), .DW(32)) dut (
        .clk(clk), .arst_l(arst_l), .se(se), .yif(yif)
    );
    sparc_exu_yreg_file #(.NTHR(8), .DW(64)) dut8 (
        .clk(clk), .arst_l(arst_l), .se(se), .yif(yif8)
    );
    sparc_exu_yreg_file #(.NTHR(1), .DW(8)) dut1 (
        .clk(clk), .arst_l(arst_l), .se(se), .yif(yif1)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic idle();
        yif.wr_w_thr   = '0; yif.wr_w_data  = '0;
        yif.wr_g_thr   = '0; yif.wr_g_data  = '0;
        yif.shift_thr  = '0; yif.shift_in   = 1'b0;
        yif8.wr_w_thr  = '0; yif8.wr_w_data = '0;
        yif8.wr_g_thr  = '0; yif8.wr_g_data = '0;
        yif8.shift_thr = '0; yif8.shift_in  = 1'b0;
        yif1.wr_w_thr  = '0; yif1.wr_w_data = '0;
        yif1.wr_g_thr  = '0; yif1.wr_g_data = '0;
        yif1.shift_thr = '0; yif1.shift_in  = 1'b0;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        arst_l = 1'b0;
        yif.rd_thr_e = '0; yif8.rd_thr_e = '0; yif1.rd_thr_e = '0;
        idle();
        repeat (2) @(posedge clk);
        #1;
        for (int t = 0; t < 4; t++) begin
            yif.rd_thr_e = 4'(1 << t);
            #1;
            total++;
            if (yif.rd_data_e !== 32'h0) begin
                bad++;
                $display("FAIL reset_rd thr=%0d got=%h exp=%h", t, yif.rd_data_e, 32'h0);
            end
        end
        total++;
        if (yif.lsb_l !== 4'hF) begin
            bad++;
            $display("FAIL reset_lsb_l got=%b exp=%b", yif.lsb_l, 4'hF);
        end
        total++;
        if (yif.err_coll !== 1'b0) begin
            bad++;
            $display("FAIL reset_err got=%b exp=0", yif.err_coll);
        end
        total++;
        if (dut.r_pend_vld !== 1'b0) begin
            bad++;
            $display("FAIL reset_pend_vld got=%b exp=0", dut.r_pend_vld);
        end
        #2 arst_l = 1'b1;
        step();
    endtask

    task automatic test_w_write();
        logic [31:0] exp_early;
`ifdef SPARC_EXU_YREG_BYPASS_EN
        exp_early = 32'hDEADBEEF;
`else
        exp_early = 32'h0;
`endif
        yif.wr_w_thr = 4'b0100; yif.wr_w_data = 32'hDEADBEEF; yif.rd_thr_e = 4'b0100;
        step();
        idle();
        #1;
        total++;
        if (yif.rd_data_e !== exp_early) begin
            bad++;
            $display("FAIL w_after_1edge got=%h exp=%h", yif.rd_data_e, exp_early);
        end
        total++;
        if (dut.r_pend_vld !== 1'b1) begin
            bad++;
            $display("FAIL w_pend_vld got=%b exp=1", dut.r_pend_vld);
        end
        step();
        total++;
        if (yif.rd_data_e !== 32'hDEADBEEF) begin
            bad++;
            $display("FAIL w_after_2edge got=%h exp=%h", yif.rd_data_e, 32'hDEADBEEF);
        end
        total++;
        if (yif.lsb_l !== 4'b1011) begin
            bad++;
            $display("FAIL w_lsb_l got=%b exp=%b", yif.lsb_l, 4'b1011);
        end
    endtask

    task automatic test_g_shift();
        yif.wr_g_thr = 4'b0010; yif.wr_g_data = 32'h12345678; yif.rd_thr_e = 4'b0010;
        step();
        idle();
        #1;
        total++;
        if (yif.rd_data_e !== 32'h12345678) begin
            bad++;
            $display("FAIL g_write got=%h exp=%h", yif.rd_data_e, 32'h12345678);
        end
        total++;
        if (yif.lsb_l[1] !== 1'b1) begin
            bad++;
            $display("FAIL g_lsb_l1 got=%b exp=1", yif.lsb_l[1]);
        end
        yif.shift_thr = 4'b0010; yif.shift_in = 1'b1;
        repeat (4) step();
        idle();
        #1;
        total++;
        if (yif.rd_data_e !== 32'hF1234567) begin
            bad++;
            $display("FAIL shift4 got=%h exp=%h", yif.rd_data_e, 32'hF1234567);
        end
        total++;
        if (yif.lsb_l[1] !== 1'b0) begin
            bad++;
            $display("FAIL shift_lsb_l1 got=%b exp=0", yif.lsb_l[1]);
        end
    endtask

    task automatic test_priority();
        yif.wr_w_thr = 4'b0001; yif.wr_w_data = 32'hA5A5A5A5; yif.rd_thr_e = 4'b0001;
        step();
        idle();
        yif.wr_g_thr = 4'b0001; yif.wr_g_data = 32'h5A5A5A5A;
        step();
        idle();
        #1;
        total++;
        if (yif.rd_data_e !== 32'hA5A5A5A5) begin
            bad++;
            $display("FAIL prio_value got=%h exp=%h", yif.rd_data_e, 32'hA5A5A5A5);
        end
        total++;
        if (yif.err_coll !== 1'b1) begin
            bad++;
            $display("FAIL prio_err_pulse got=%b exp=1", yif.err_coll);
        end
        step();
        total++;
        if (yif.err_coll !== 1'b0) begin
            bad++;
            $display("FAIL prio_err_clear got=%b exp=0", yif.err_coll);
        end
        total++;
        if (yif.rd_data_e !== 32'hA5A5A5A5) begin
            bad++;
            $display("FAIL prio_hold got=%h exp=%h", yif.rd_data_e, 32'hA5A5A5A5);
        end
    endtask

    task automatic test_parallel();
        logic [31:0] exp_v [4];
        exp_v[0] = 32'h11111111; exp_v[1] = 32'h22222222;
        exp_v[2] = 32'hDEADBEEF; exp_v[3] = 32'h80000000;
        yif.wr_w_thr = 4'b0001; yif.wr_w_data = 32'h11111111; yif.rd_thr_e = 4'b0000;
        step();
        idle();
        yif.wr_g_thr = 4'b0010; yif.wr_g_data = 32'h22222222;
        yif.shift_thr = 4'b1000; yif.shift_in = 1'b1;
        step();
        idle();
        #1;
        total++;
        if (yif.err_coll !== 1'b0) begin
            bad++;
            $display("FAIL par_err got=%b exp=0", yif.err_coll);
        end
        for (int t = 0; t < 4; t++) begin
            yif.rd_thr_e = 4'(1 << t);
            #1;
            total++;
            if (yif.rd_data_e !== exp_v[t]) begin
                bad++;
                $display("FAIL par_value thr=%0d got=%h exp=%h", t, yif.rd_data_e, exp_v[t]);
            end
        end
        total++;
        if (yif.lsb_l !== 4'b1010) begin
            bad++;
            $display("FAIL par_lsb_l got=%b exp=%b", yif.lsb_l, 4'b1010);
        end
    endtask

    task automatic test_reset_pending();
        yif.wr_w_thr = 4'b1000; yif.wr_w_data = 32'hCAFEF00D; yif.rd_thr_e = 4'b1000;
        step();
        idle();
        total++;
        if (dut.r_pend_vld !== 1'b1) begin
            bad++;
            $display("FAIL rstp_captured got=%b exp=1", dut.r_pend_vld);
        end
        arst_l = 1'b0;
        #1;
        total++;
        if (dut.r_pend_vld !== 1'b0) begin
            bad++;
            $display("FAIL rstp_pend_in_reset got=%b exp=0", dut.r_pend_vld);
        end
        #1 arst_l = 1'b1;
        step();
        total++;
        if (yif.rd_data_e !== 32'h0) begin
            bad++;
            $display("FAIL rstp_thr3 got=%h exp=%h", yif.rd_data_e, 32'h0);
        end
        total++;
        if (dut.r_pend_vld !== 1'b0) begin
            bad++;
            $display("FAIL rstp_pend_after got=%b exp=0", dut.r_pend_vld);
        end
        total++;
        if (yif.lsb_l !== 4'hF) begin
            bad++;
            $display("FAIL rstp_lsb_l got=%b exp=%b", yif.lsb_l, 4'hF);
        end
    endtask

    task automatic test_multi_read();
        yif.wr_g_thr  = 4'b0001; yif.wr_g_data  = 32'h000000FF; yif.rd_thr_e  = 4'b0001;
        yif8.wr_g_thr = 8'h01;   yif8.wr_g_data = 64'h0123456789ABCDEF; yif8.rd_thr_e = 8'h01;
        step();
        idle();
        #1;
        total++;
        if (yif.rd_data_e !== 32'h000000FF) begin
            bad++;
            $display("FAIL mr_single got=%h exp=%h", yif.rd_data_e, 32'h000000FF);
        end
        total++;
        if (yif8.rd_data_e !== 64'h0123456789ABCDEF) begin
            bad++;
            $display("FAIL mr8_single got=%h exp=%h", yif8.rd_data_e, 64'h0123456789ABCDEF);
        end
        yif.rd_thr_e = 4'b0011; yif8.rd_thr_e = 8'h03;
        #1;
        total++;
        if (yif.rd_data_e !== 32'h0) begin
            bad++;
            $display("FAIL mr_multi_data got=%h exp=%h", yif.rd_data_e, 32'h0);
        end
        total++;
        if (yif8.rd_data_e !== 64'h0) begin
            bad++;
            $display("FAIL mr8_multi_data got=%h exp=%h", yif8.rd_data_e, 64'h0);
        end
        step();
        yif.rd_thr_e = 4'b0001; yif8.rd_thr_e = 8'h01;
        total++;
        if (yif.err_coll !== 1'b1) begin
            bad++;
            $display("FAIL mr_err got=%b exp=1", yif.err_coll);
        end
        total++;
        if (yif8.err_coll !== 1'b1) begin
            bad++;
            $display("FAIL mr8_err got=%b exp=1", yif8.err_coll);
        end
        step();
        total++;
        if (yif.err_coll !== 1'b0) begin
            bad++;
            $display("FAIL mr_err_clear got=%b exp=0", yif.err_coll);
        end
    endtask

    task automatic test_onehot_err();
        yif.wr_g_thr = 4'b0110; yif.wr_g_data = 32'h0;
        step();
        idle();
        total++;
        if (yif.err_coll !== 1'b1) begin
            bad++;
            $display("FAIL g_multihot_err got=%b exp=1", yif.err_coll);
        end
        step();
        total++;
        if (yif.err_coll !== 1'b0) begin
            bad++;
            $display("FAIL g_multihot_clear got=%b exp=0", yif.err_coll);
        end
    endtask

    task automatic test_single_thread();
        yif1.wr_g_thr = 1'b1; yif1.wr_g_data = 8'hAB; yif1.rd_thr_e = 1'b1;
        step();
        idle();
        #1;
        total++;
        if (yif1.rd_data_e !== 8'hAB) begin
            bad++;
            $display("FAIL n1_g got=%h exp=%h", yif1.rd_data_e, 8'hAB);
        end
        yif1.shift_thr = 1'b1; yif1.shift_in = 1'b0;
        step();
        idle();
        #1;
        total++;
        if (yif1.rd_data_e !== 8'h55) begin
            bad++;
            $display("FAIL n1_shift got=%h exp=%h", yif1.rd_data_e, 8'h55);
        end
        total++;
        if (yif1.lsb_l !== 1'b0) begin
            bad++;
            $display("FAIL n1_lsb_l got=%b exp=0", yif1.lsb_l);
        end
    endtask

    initial begin
        total = 0;
        bad   = 0;
        se    = 1'b0;
        test_reset();
        test_w_write();
        test_g_shift();
        test_priority();
        test_parallel();
        test_reset_pending();
        test_multi_read();
        test_onehot_err();
        test_single_thread();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
